// File: rtl/paint_pkg.sv
// Shared canvas definitions for the paint plot/read paths: default widths,
// reader FSM encoding and the packed pixel tuple.
package paint_pkg;

    localparam int PAINT_X_W      = 8;
    localparam int PAINT_Y_W      = 7;
    localparam int PAINT_COLOUR_W = 3;
    localparam int PAINT_SIZE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } rs_state_t;

    typedef struct packed {
        logic [PAINT_X_W-1:0]      x;
        logic [PAINT_Y_W-1:0]      y;
        logic [PAINT_COLOUR_W-1:0] colour;
        logic                      last;
    } pix_t;

endpackage

// File: rtl/read_square_if.sv
// Canvas RAM read port plus the pixel-tuple stream towards the consumer.
interface read_square_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                 mem_rd_en;
    logic [X_W+Y_W-1:0]   mem_addr;
    logic [COLOUR_W-1:0]  mem_rdata;

    logic                 pix_valid;
    logic                 pix_ready;
    logic [X_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic [COLOUR_W-1:0]  pix_colour;
    logic                 pix_last;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output pix_valid, pix_x, pix_y, pix_colour, pix_last,
        input  pix_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  pix_valid, pix_x, pix_y, pix_colour, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/pixel_fifo2.sv
// Two-entry synchronous FIFO: push side reports occupancy, pop side is valid/ready.
module pixel_fifo2 #(
    parameter int W = 19
)(
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [1:0]   occ,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] slot [2];
    logic         wptr;
    logic         rptr;
    logic         pop;

    assign out_valid = (occ != 2'd0);
    assign out_data  = slot[rptr];
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wptr    <= 1'b0;
            rptr    <= 1'b0;
            occ     <= 2'd0;
        end else begin
            if (push) begin
                slot[wptr] <= push_data;
                wptr       <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            occ <= occ + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/read_square.sv
// Raster-scans a rectangular canvas region through a synchronous RAM and streams
// (x, y, colour, last) tuples out. States: IDLE | waiting for start,
// SCAN | issuing reads, DRAIN | all reads issued, waiting for the last tuple.
module read_square
    import paint_pkg::*;
#(
    parameter int X_W      = PAINT_X_W,
    parameter int Y_W      = PAINT_Y_W,
    parameter int SIZE_W   = PAINT_SIZE_W,
    parameter int COLOUR_W = PAINT_COLOUR_W
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [X_W-1:0]    base_x,
    input  logic [Y_W-1:0]    base_y,
    input  logic [SIZE_W-1:0] size_x,
    input  logic [SIZE_W-1:0] size_y,
    output logic              busy,
    output logic              done,
    read_square_if.master     bus
);
    localparam int TW = X_W + Y_W + COLOUR_W + 1;

    rs_state_t          state;
    logic [X_W-1:0]     bx;
    logic [Y_W-1:0]     by;
    logic [SIZE_W-1:0]  sx;
    logic [SIZE_W-1:0]  sy;
    logic [SIZE_W-1:0]  ox;
    logic [SIZE_W-1:0]  oy;

    logic               inflight;
    logic [X_W-1:0]     tag_x;
    logic [Y_W-1:0]     tag_y;
    logic               tag_last;

    logic [X_W-1:0]     rd_x;
    logic [Y_W-1:0]     rd_y;
    logic               at_end;
    logic               issue;
    logic               pop;
    logic [1:0]         occ;
    logic [2:0]         outstanding;
    logic               fifo_valid;
    logic               head_last;
    logic [TW-1:0]      head;

    assign rd_x   = bx + X_W'(ox);
    assign rd_y   = by + Y_W'(oy);
    assign at_end = (ox == sx) && (oy == sy);
    assign pop    = fifo_valid & bus.pix_ready;

    // Queued entries plus the read in flight, less the one leaving this cycle,
    // must leave room so the FIFO can never overflow.
    assign outstanding = 3'(occ) + 3'(inflight) - 3'(pop);
    assign issue       = (state == SCAN) && (outstanding < 3'd2);

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = {rd_y, rd_x};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bx       <= '0;
            by       <= '0;
            sx       <= '0;
            sy       <= '0;
            ox       <= '0;
            oy       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            inflight <= 1'b0;
            tag_x    <= '0;
            tag_y    <= '0;
            tag_last <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                tag_x    <= rd_x;
                tag_y    <= rd_y;
                tag_last <= at_end;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        bx    <= base_x;
                        by    <= base_y;
                        sx    <= size_x;
                        sy    <= size_y;
                        ox    <= '0;
                        oy    <= '0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (issue) begin
                        if (at_end) begin
                            state <= DRAIN;
                        end else if (ox == sx) begin
                            ox <= '0;
                            oy <= oy + SIZE_W'(1);
                        end else begin
                            ox <= ox + SIZE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pixel_fifo2 #(.W(TW)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (inflight),
        .push_data ({tag_x, tag_y, bus.mem_rdata, tag_last}),
        .occ       (occ),
        .out_valid (fifo_valid),
        .out_ready (bus.pix_ready),
        .out_data  (head)
    );

    assign {bus.pix_x, bus.pix_y, bus.pix_colour, head_last} = head;
    assign bus.pix_valid = fifo_valid;
    assign bus.pix_last  = fifo_valid & head_last;
endmodule

// File: doc/read_square.md
Name: read_square

Overview:
- Reads back a rectangular pixel region from the paint canvas RAM.
- It is the reader counterpart of the square-plotting coordinate generator.
- On start it scans (size_x+1) x (size_y+1) pixels anchored at (base_x, base_y), issues synchronous RAM reads, and streams (x, y, colour) tuples to a consumer over a valid/ready handshake.
- Used for colour-pick, copy and undo-capture paths.

Parameters:
X_W, 8, canvas x coordinate width
Y_W, 7, canvas y coordinate width
SIZE_W, 4, region extent field width (extent = field+1, max 16)
COLOUR_W, 3, pixel colour width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  request a scan; sampled only in IDLE
base_x  in  X_W  region origin x, latched on accepted start
base_y  in  Y_W  region origin y, latched on accepted start
size_x  in  SIZE_W  region width minus one, latched on accepted start
size_y  in  SIZE_W  region height minus one, latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last pixel handshake
mem_rd_en  out  1  canvas RAM read strobe
mem_addr  out  X_W+Y_W  canvas address = {y, x}
mem_rdata  in  COLOUR_W  RAM data, valid exactly one cycle after mem_rd_en
pix_valid  out  1  output tuple valid
pix_ready  in  1  consumer accepts tuple
pix_x  out  X_W  pixel x
pix_y  out  Y_W  pixel y
pix_colour  out  COLOUR_W  pixel colour
pix_last  out  1  tuple is final pixel of region

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, mem_rd_en, pix_valid, pix_last = 0; mem_addr, pix_x, pix_y, pix_colour = 0; FIFO emptied; in-flight read discarded.
- States: IDLE, SCAN, DRAIN.
- IDLE:
  - start=1 at an edge latches base/size, clears offsets ox=oy=0, sets busy, and moves to SCAN.
  - start while busy is ignored.
- SCAN:
  - A read is issued (mem_rd_en=1) in a cycle when FIFO occupancy + in-flight reads - (pix_valid & pix_ready) < 2.
  - Read address: x = base_x + ox mod 2^X_W, y = base_y + oy mod 2^Y_W. Coordinates wrap silently.
  - Scan order is raster: ox increments 0..size_x; at size_x it resets to 0 and oy increments.
  - After issuing (ox=size_x, oy=size_y), go to DRAIN. No further reads.
- Read pipeline:
  - The in-flight flag and tag (x, y, last) are registered alongside mem_rd_en.
  - The next edge pushes {x, y, mem_rdata, last} into a 2-entry FIFO.
  - The FIFO head drives pix_*; pix_valid = FIFO non-empty.
- Latency: start sampled at edge E0 -> mem_rd_en high after E0 -> first pix_valid high after E2. Throughput is 1 pixel/cycle while pix_ready=1.
- Handshake:
  - A transfer occurs when pix_valid & pix_ready.
  - pix_* hold stable while pix_valid=1 and pix_ready=0.
  - The FIFO never overflows; the issue rule guarantees this.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- DRAIN: when the pix_last tuple transfers, go to IDLE. busy drops and done=1 in the following cycle.
- done is exactly one cycle; start on the done cycle is accepted.
- Total transfers per scan = (size_x+1)*(size_y+1); size 0,0 -> 1 pixel with pix_last=1.
- resetn low mid-scan: immediate abort. No done pulse. Partial output is dropped.

Decomposition:
- Package paint_pkg holds:
  - X_W/Y_W/COLOUR_W defaults, shared with the plot side.
  - State encoding constants IDLE/SCAN/DRAIN.
  - Packed pixel tuple typedef {x, y, colour, last}.
- Sub-module pixel_fifo2: 2-entry synchronous FIFO with async active-low reset, valid/ready on the output side, push/occupancy on the input side.

Test Plan:
- 1x1: base (10,20), size (0,0), ready=1 -> one tuple (10,20,mem[{20,10}]) with pix_last=1; pix_valid 3 cycles after start edge; done 1 cycle after transfer.
- 4x3 streaming: base (5,5), size (3,2), ready=1 -> 12 tuples in raster order (5,5)..(8,5),(5,6)..(8,7). One per cycle after the first. Only (8,7) has pix_last.
- Backpressure: same 4x3 with pix_ready toggled randomly and held low 5 cycles -> outputs stable while stalled; no loss or duplicate; ≤2 outstanding reads+entries; exactly 12 transfers.
- Wrap: base (254,126), size (2,1) -> x sequence 254,255,0; y 126,127; addresses wrap accordingly.
- Start while busy: second start during a 4x4 scan with different base -> ignored; 16 tuples from the original base.
- Reset mid-scan: resetn low after 5 transfers -> all outputs 0 immediately. A new start after release yields a complete correct scan starting at offset 0.
